// File: rtl/fifo_pkg.sv
// fifo_pkg: shared read-mode type and pointer sizing helper for the single-clock FIFO
package fifo_pkg;
  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_level_ctrl.sv
// fifo_level_ctrl: accept logic, pointers, occupancy, threshold flags and sticky error flags
module fifo_level_ctrl import fifo_pkg::*; #(
  parameter int Depth    = 16,
  parameter int AfThresh = 12,
  parameter int AeThresh = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_wr_en,
  input  logic                     i_rd_en,
  input  logic                     i_clr_err,
  output logic                     o_wr_acc,
  output logic                     o_rd_acc,
  output logic [$clog2(Depth)-1:0] o_wr_addr,
  output logic [$clog2(Depth)-1:0] o_rd_addr,
  output logic [$clog2(Depth):0]   o_level,
  output logic                     o_full,
  output logic                     o_almost_full,
  output logic                     o_empty,
  output logic                     o_almost_empty,
  output logic                     o_overflow,
  output logic                     o_underflow
);
  localparam int PW = ptr_width(Depth);
  localparam int AW = $clog2(Depth);
  localparam logic [PW-1:0] DL  = PW'(Depth);
  localparam logic [PW-1:0] AFL = PW'(AfThresh);
  localparam logic [PW-1:0] AEL = PW'(AeThresh);
  logic [PW-1:0] wr_ptr, rd_ptr, level;
  assign o_full         = level == DL;
  assign o_empty        = level == '0;
  assign o_almost_full  = level >= AFL;
  assign o_almost_empty = level <= AEL;
  assign o_wr_acc       = i_wr_en & ~o_full;
  assign o_rd_acc       = i_rd_en & ~o_empty;
  assign o_wr_addr      = wr_ptr[AW-1:0];
  assign o_rd_addr      = rd_ptr[AW-1:0];
  assign o_level        = level;
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(o_wr_acc);
      rd_ptr <= rd_ptr + PW'(o_rd_acc);
      level  <= level + PW'(o_wr_acc) - PW'(o_rd_acc);
    end
  end
  // a flush leaves the error flags untouched, including any pending clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (!i_flush) begin
      o_overflow  <= (o_overflow & ~i_clr_err) | (i_wr_en & o_full);
      o_underflow <= (o_underflow & ~i_clr_err) | (i_rd_en & o_empty);
    end
  end
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with standard or first-word-fall-through read path
module sync_fifo_ctrl import fifo_pkg::*; #(
  parameter int         Depth    = 16,
  parameter int         Width    = 8,
  parameter fifo_mode_e Mode     = FIFO_STD,
  parameter int         AfThresh = 12,
  parameter int         AeThresh = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_wr_en,
  input  logic [Width-1:0]       i_wr_data,
  input  logic                   i_rd_en,
  output logic [Width-1:0]       o_rd_data,
  output logic                   o_rd_valid,
  output logic                   o_full,
  output logic                   o_almost_full,
  output logic                   o_empty,
  output logic                   o_almost_empty,
  output logic [$clog2(Depth):0] o_level,
  output logic                   o_overflow,
  output logic                   o_underflow,
  input  logic                   i_clr_err
);
  localparam int AW = $clog2(Depth);
  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("Depth must be a power of two >= 2");
  end
  if (AfThresh < 1 || AfThresh > Depth) begin : g_bad_af
    $error("AfThresh out of range");
  end
  if (AeThresh < 0 || AeThresh > Depth - 1) begin : g_bad_ae
    $error("AeThresh out of range");
  end
  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] rd_q;
  logic             vld_q;
  logic             wr_acc, rd_acc;
  logic [AW-1:0]    wr_addr, rd_addr;
  fifo_level_ctrl #(.Depth(Depth), .AfThresh(AfThresh), .AeThresh(AeThresh)) u_ctrl (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_wr_en(i_wr_en), .i_rd_en(i_rd_en),
    .i_clr_err(i_clr_err), .o_wr_acc(wr_acc), .o_rd_acc(rd_acc), .o_wr_addr(wr_addr),
    .o_rd_addr(rd_addr), .o_level(o_level), .o_full(o_full), .o_almost_full(o_almost_full),
    .o_empty(o_empty), .o_almost_empty(o_almost_empty), .o_overflow(o_overflow),
    .o_underflow(o_underflow)
  );
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_addr] <= i_wr_data;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q  <= '0;
      vld_q <= 1'b0;
    end else if (i_flush) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= rd_acc;
      if (rd_acc) rd_q <= mem[rd_addr];
    end
  end
  assign o_rd_data  = (Mode == FIFO_FWFT) ? mem[rd_addr] : rd_q;
  assign o_rd_valid = (Mode == FIFO_FWFT) ? ~o_empty : vld_q;
endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock, parametrised FIFO for same-domain buffering; counterpart to the dual-clock FIFO.
- Adds selectable standard/first-word-fall-through (FWFT) read mode.
- Adds programmable almost-full/almost-empty thresholds and a fill-level output.
- Adds synchronous flush and sticky overflow/underflow error flags.
- Used wherever producer and consumer share clk and need back-pressure headroom.

Parameters:
Depth, 16, number of entries; power of two, >= 2
Width, 8, data word width in bits
Mode, FIFO_STD, read mode: FIFO_STD (registered read data) or FIFO_FWFT (head word presented)
AfThresh, 12, o_almost_full asserted when level >= AfThresh; 1..Depth
AeThresh, 4, o_almost_empty asserted when level <= AeThresh; 0..Depth-1

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
i_flush  input  1  synchronous flush; empties FIFO
i_wr_en  input  1  write request
i_wr_data  input  Width  write data
i_rd_en  input  1  read request (FWFT: pop head)
o_rd_data  output  Width  read data
o_rd_valid  output  1  STD: one-cycle pulse with returned data; FWFT: head valid (= ~o_empty)
o_full  output  1  level == Depth
o_almost_full  output  1  level >= AfThresh
o_empty  output  1  level == 0
o_almost_empty  output  1  level <= AeThresh
o_level  output  $clog2(Depth)+1  current occupancy, 0..Depth
o_overflow  output  1  sticky: write attempted while full
o_underflow  output  1  sticky: read attempted while empty
i_clr_err  input  1  clears o_overflow/o_underflow

Behaviour:
- Reset (rst_n low at clk edge): pointers, level, o_rd_valid, o_rd_data, error flags = 0; o_empty = 1, o_almost_empty = 1, o_full = 0, o_almost_full = 0. Memory array is not reset.
- Pointers: binary, $clog2(Depth)+1 bits; low bits address memory; wrap naturally at 2*Depth.
- Accept rules:
  - wr_acc = i_wr_en & ~o_full
  - rd_acc = i_rd_en & ~o_empty
- Flags are evaluated on the current registered level. There is no write pass-through when full and no read pass-through when empty.
- Level update: level_next = level + wr_acc - rd_acc.
  - Simultaneous accepted read and write leaves level unchanged; both pointers advance.
- Flags are combinational decodes of the registered level, so they change the cycle after the accepting edge.
- STD mode:
  - Accepted read at edge N: o_rd_data = mem[rd_ptr] and o_rd_valid = 1 after edge N (1-cycle latency).
  - o_rd_valid = 0 in cycles with no accepted read; o_rd_data holds its last value.
- FWFT mode:
  - o_rd_data = mem[rd_ptr] combinationally; o_rd_valid = ~o_empty.
  - A word written at edge N is visible on o_rd_data after edge N (write-to-head latency 1).
  - i_rd_en pops at the edge.
- Errors:
  - i_wr_en & o_full sets o_overflow; i_rd_en & o_empty sets o_underflow.
  - Both are sticky until i_clr_err. Set wins over clear in the same cycle.
- Flush:
  - i_flush = 1 zeroes pointers, level and o_rd_valid at the edge.
  - Same-cycle wr/rd requests are dropped and do not set error flags.
  - Error flags are unaffected; o_rd_data holds its value.
- Priority: rst_n > i_flush > normal operation.
- Reset asserted mid-operation discards contents exactly like flush and also clears the error flags.

Decomposition:
- Package fifo_pkg:
  - fifo_mode_e enum {FIFO_STD, FIFO_FWFT}
  - helper function ptr_width(depth)
- Sub-module fifo_level_ctrl: accept logic, pointers, level counter, full/empty/almost flags and error flags.
- Top-level holds the memory array and the read-data path per Mode.
- Elaboration checks: Depth power of two; AfThresh/AeThresh in range.

Test Plan:
1. Defaults, STD: write 16 words 0x00..0x0F, then read 16 -> o_full=1 after 16th write edge; o_almost_full=1 from level 12; reads return 0x00..0x0F each with o_rd_valid pulse 1 cycle after read; o_empty=1 at end; o_level tracks 16 -> 0.
2. Full/empty abuse: with level 16 assert i_wr_en with 0xAA -> no write, o_overflow=1, level stays 16; drain to 0, assert i_rd_en -> o_underflow=1, o_rd_valid=0; pulse i_clr_err -> both flags 0.
3. Simultaneous read+write at level 16 and at level 0 -> at 16: read accepted, write rejected, level 15, o_overflow=1; at 0: write accepted, read rejected, level 1, o_underflow=1.
4. Wrap-around: 40 cycles of continuous write+read at level 5 with incrementing data -> level stays 5, data order preserved across pointer wrap at 32.
5. FWFT mode: write 0x5A at edge N -> o_rd_data=0x5A, o_rd_valid=1 after edge N; assert i_rd_en -> o_empty=1 next cycle.
6. Flush/reset mid-stream: level 9, assert i_flush with i_wr_en=1 -> level 0, o_empty=1, error flags unchanged; repeat with rst_n=0 -> all outputs at reset values including error flags.
